// File: rtl/midi_rx_if.sv
// MIDI receiver bus: serial line in, decoded channel / real-time messages out.
// The receiver sources messages (master); the consumer drives the line (slave).
interface midi_rx_if;
    logic       midi_rx;
    logic       msg_valid;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic       frame_err;

    modport master (
        input  midi_rx,
        output msg_valid, msg_status, msg_data1, msg_data2,
        output rt_valid, rt_byte, frame_err
    );

    modport slave (
        output midi_rx,
        input  msg_valid, msg_status, msg_data1, msg_data2,
        input  rt_valid, rt_byte, frame_err
    );
endinterface

// File: rtl/midi_rx.sv
// MIDI serial receiver: 8N1 bit FSM feeding a running-status channel-message parser,
// with real-time bytes passed straight through.
module midi_rx #(
    parameter int BIT_CNT     = 3200,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    midi_rx_if.master bus
);

    localparam int CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam logic [CW-1:0] LAST      = CW'(BIT_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CNT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   rx_s;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic [7:0]             run_status;
    logic                   need2;
    logic                   data_idx;
    logic [7:0]             data1_buf;

    // Input synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p <= '1;
        end else begin
            sync_p[0] <= bus.midi_rx;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign rx_s = sync_p[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            run_status     <= '0;
            need2          <= 1'b0;
            data_idx       <= 1'b0;
            data1_buf      <= '0;
            bus.msg_valid  <= 1'b0;
            bus.msg_status <= '0;
            bus.msg_data1  <= '0;
            bus.msg_data2  <= '0;
            bus.rt_valid   <= 1'b0;
            bus.rt_byte    <= '0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.msg_valid <= 1'b0;
            bus.rt_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            bus.frame_err <= 1'b1;
                            state         <= BREAK;
                        end else begin
                            state <= IDLE;
                            // Byte accepted: real-time bytes bypass the parser entirely
                            if (shreg[7:3] == 5'b11111) begin
                                bus.rt_byte  <= shreg;
                                bus.rt_valid <= 1'b1;
                            end else if (shreg[7:4] == 4'hF) begin
                                run_status <= '0;
                                data_idx   <= 1'b0;
                            end else if (shreg[7]) begin
                                run_status <= shreg;
                                data_idx   <= 1'b0;
                                need2      <= !(shreg[7:4] == 4'hC || shreg[7:4] == 4'hD);
                            end else if (run_status[7]) begin
                                if (!data_idx && !need2) begin
                                    bus.msg_valid  <= 1'b1;
                                    bus.msg_status <= run_status;
                                    bus.msg_data1  <= shreg;
                                    bus.msg_data2  <= '0;
                                end else if (!data_idx) begin
                                    data1_buf <= shreg;
                                    data_idx  <= 1'b1;
                                end else begin
                                    bus.msg_valid  <= 1'b1;
                                    bus.msg_status <= run_status;
                                    bus.msg_data1  <= data1_buf;
                                    bus.msg_data2  <= shreg;
                                    data_idx       <= 1'b0;
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_rx.sv
// Bench for midi_rx: serial byte driver, event scoreboard, monitor on the falling edge.
module tb_midi_rx;

    localparam int BIT_CNT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    midi_rx_if bus ();

    midi_rx #(.BIT_CNT(BIT_CNT), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    // Event: {is_rt, status/rt_byte, data1, data2}
    logic [24:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
        sb_q.push_back({1'b0, s, d1, d2});
    endtask

    task automatic exp_rt(input logic [7:0] b);
        sb_q.push_back({1'b1, b, 16'h0000});
    endtask

    task automatic bit_time();
        repeat (BIT_CNT) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.midi_rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            bus.midi_rx = b[i];
            bit_time();
        end
        bus.midi_rx = stop_bit;
        bit_time();
        bus.midi_rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic settle();
        repeat (BIT_CNT * 2) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("frame_err_cnt", 32'(fe_seen), 32'(fe_exp));
    endtask

    always @(negedge clk) begin
        logic [24:0] ev;
        if (bus.frame_err) fe_seen++;
        if (bus.msg_valid && bus.rt_valid) check_eq("both_valid", 32'd1, 32'd0);
        if (bus.msg_valid || bus.rt_valid) begin
            ev = bus.rt_valid ? {1'b1, bus.rt_byte, 16'h0000}
                              : {1'b0, bus.msg_status, bus.msg_data1, bus.msg_data2};
            if (sb_q.size() == 0) check_eq("unexpected_evt", 32'(ev), 32'hDEAD0000);
            else check_eq(bus.rt_valid ? "rt_evt" : "msg_evt", 32'(ev), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        bus.midi_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {bus.msg_valid, bus.rt_valid, bus.frame_err, bus.msg_status,
                                bus.msg_data1, bus.msg_data2}, 32'd0);
        check_eq("reset_rt", 32'(bus.rt_byte), 32'd0);
        rst = 1'b1;

        // Basic three-byte message
        send(8'hB0); send(8'h2E); exp_msg(8'hB0, 8'h2E, 8'h7F); send(8'h7F);
        settle();

        // Running status
        send(8'hB0); send(8'h2E); exp_msg(8'hB0, 8'h2E, 8'h7F); send(8'h7F);
        send(8'h2F); exp_msg(8'hB0, 8'h2F, 8'h40); send(8'h40);
        settle();

        // Partial message abandoned by a new status
        send(8'h90); send(8'h3C);
        send(8'hB0); send(8'h2E); exp_msg(8'hB0, 8'h2E, 8'h7F); send(8'h7F);
        settle();

        // One-data message, then real-time byte inside a note-on
        send(8'hC3); exp_msg(8'hC3, 8'h05, 8'h00); send(8'h05);
        send(8'h90); send(8'h3C); exp_rt(8'hF8); send(8'hF8);
        exp_msg(8'h90, 8'h3C, 8'h64); send(8'h64);
        settle();
        check_eq("hold_status", 32'(bus.msg_status), 32'h90);
        check_eq("hold_data1", 32'(bus.msg_data1), 32'h3C);
        check_eq("hold_data2", 32'(bus.msg_data2), 32'h64);
        check_eq("hold_rt", 32'(bus.rt_byte), 32'hF8);

        // Framing error, then recovery
        fe_exp++;
        send_byte(8'h2E, 1'b0);
        bus.midi_rx = 1'b1;
        settle();
        send(8'hB0); send(8'h2E); exp_msg(8'hB0, 8'h2E, 8'h7F); send(8'h7F);
        settle();

        // Short glitch, then sysex clears running status
        bus.midi_rx = 1'b0;
        #60;
        bus.midi_rx = 1'b1;
        settle();
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7);
        send(8'h2E); send(8'h7F);
        settle();
        check_eq("hold_after_sysex", {8'h00, bus.msg_status, bus.msg_data1, bus.msg_data2},
                 32'h00B02E7F);

        // Reset in the middle of a byte
        send(8'hB0);
        bus.midi_rx = 1'b0;
        repeat (BIT_CNT * 3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("midreset_outs", {bus.msg_valid, bus.rt_valid, bus.frame_err, bus.msg_status,
                                   bus.msg_data1, bus.msg_data2}, 32'd0);
        bus.midi_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("midreset_rt", 32'(bus.rt_byte), 32'd0);
        rst = 1'b1;
        send(8'h2E); send(8'h7F);
        send(8'hB0); send(8'h2E); exp_msg(8'hB0, 8'h2E, 8'h7F); send(8'h7F);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/midi_rx.md
MIDI_RX -- requirements
Module: midi_rx

Interface
REQ-001 SHALL have parameter BIT_CNT, default 3200; clk cycles per MIDI bit (31250 baud at 100 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2; depth of the input synchronizer.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 midi_rx  input  1  serial MIDI line, idle high, asynchronous to clk.
REQ-006 msg_valid  output  1  one-clk pulse; a complete channel message is on msg_*.
REQ-007 msg_status  output  8  status byte of the completed message.
REQ-008 msg_data1  output  8  first data byte.
REQ-009 msg_data2  output  8  second data byte; 0 for one-data-byte messages.
REQ-010 rt_valid  output  1  one-clk pulse; a real-time byte is on rt_byte.
REQ-011 rt_byte  output  8  received real-time byte (F8-FF).
REQ-012 frame_err  output  1  one-clk pulse on a stop-bit error.

Function
REQ-013 SHALL pass midi_rx through SYNC_STAGES flops reset to 1; all decoding uses the synchronized signal rx_s.
REQ-014 Bit FSM states SHALL be IDLE, START, DATA, STOP, BREAK; reset state IDLE.
REQ-015 IDLE: rx_s==0 -> START, bit counter cleared.
REQ-016 START: at BIT_CNT/2 cycles, sample rx_s; 0 -> DATA; 1 -> IDLE (glitch rejected, no output).
REQ-017 DATA: sample every BIT_CNT cycles after the start mid-sample; 8 bits, LSB first; after the 8th -> STOP.
REQ-018 STOP: sample BIT_CNT cycles later; 1 -> byte accepted, IDLE; 0 -> frame_err pulse, byte discarded, BREAK.
REQ-019 BREAK: wait for rx_s==1, then IDLE; no bytes accepted meanwhile.
REQ-020 Byte counter SHALL be wide enough for BIT_CNT-1 and SHALL not wrap within a bit period.
REQ-021 Accepted byte F8-FF: rt_byte=byte, rt_valid pulse; parser running status and data index unchanged.
REQ-022 Accepted byte F0-F7: running status cleared; data bytes ignored until the next channel status.
REQ-023 Accepted byte 80-EF: running status=byte, data index=0; needed count=1 for Cx/Dx, else 2.
REQ-024 Accepted byte 00-7F with no running status: discarded.
REQ-025 Data byte with running status: index 0 -> data1, index 1 -> data2; on reaching needed count, msg_valid pulse, index=0, running status retained.
REQ-026 Completed one-data messages SHALL present msg_data2=0.
REQ-027 msg_valid/rt_valid SHALL assert on the clk after the stop-bit sample of the completing byte; never both in one cycle.
REQ-028 msg_status/msg_data1/msg_data2 and rt_byte SHALL hold until their next valid pulse.
REQ-029 New status byte arriving mid-message SHALL abandon the partial message without a msg_valid.

Reset
REQ-030 rst low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1s, running status cleared, all outputs 0.
REQ-031 rst deasserted mid-frame SHALL resume at IDLE; the interrupted byte SHALL produce no output.

Verification
REQ-032 Send B0 2E 7F -> exactly one msg_valid, status B0, data1 2E, data2 7F.
REQ-033 Send B0 2E 7F 2F 40 (running status) -> two msg_valid: (B0,2E,7F) then (B0,2F,40).
REQ-034 Send C3 05 -> msg_valid with (C3,05,00); send 90 3C F8 64 -> rt_valid F8 before msg_valid (90,3C,64).
REQ-035 Byte 2E with stop bit 0 -> frame_err pulse, no msg_valid; line high then B0 2E 7F decodes normally.
REQ-036 60 ns low glitch on idle line -> no output; F0 01 02 F7 followed by 2E 7F -> no msg_valid.
REQ-037 Assert rst mid-byte of B0 2E 7F, release, send B0 2E 7F -> outputs 0 during reset, then one msg_valid (B0,2E,7F).
